fp16_operand_entry: RTL and testbench

- Upstream feeder for the FP16 adder.
- Converts single-cycle keypad events (raw 4-bit key index) into two 16-bit half-precision operands, A then B.
- Each operand is built as four hex digits, most significant digit first.
- Presents the completed pair to the adder via a valid/ready handshake and exposes the in-progress digits and state for the HEX/LED display.

---
 rtl/fp_entry_pkg.sv | 26 ++
 rtl/fp16_operand_entry_if.sv | 38 +++
 rtl/keypad_hex_decode.sv | 45 ++++
 rtl/fp16_operand_entry.sv | 122 ++++++++++++
 tb/tb_fp16_operand_entry.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_entry_pkg.sv
// Shared types and constants for the FP16 operand-entry keypad front end.
package fp_entry_pkg;

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    HOLD    = 2'b10
  } state_e;

  localparam int DEF_DIGITS    = 4;
  localparam int DEF_KEY_BKSP  = 12;
  localparam int DEF_KEY_ENTER = 14;

  localparam int FP16_SIGN_BIT = 15;
  localparam int FP16_EXP_MSB  = 14;
  localparam int FP16_EXP_LSB  = 10;
  localparam int FP16_MAN_MSB  = 9;
  localparam int FP16_MAN_LSB  = 0;
  localparam logic [4:0] EXP_ALL_ONES = 5'b11111;

  // True for Inf/NaN bit patterns.
  function automatic logic fp16_is_special(input logic [15:0] word);
    return word[FP16_EXP_MSB:FP16_EXP_LSB] == EXP_ALL_ONES;
  endfunction

endpackage

// File: rtl/fp16_operand_entry_if.sv
// Keypad-in / operand-pair-out bundle. Optional FP16_SPECIAL_REJECT_EN adds special_seen.
interface fp16_operand_entry_if #(
  parameter int W = 16
) ();

  logic         key_valid;
  logic [3:0]   key_code;
  logic         op_ready;
  logic         op_valid;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] entry_word;
  logic [2:0]   digit_cnt;
  logic [1:0]   state_led;
  logic         err;
`ifdef FP16_SPECIAL_REJECT_EN
  logic         special_seen;

  modport master (
    input  key_valid, key_code, op_ready,
    output op_valid, op_a, op_b, entry_word, digit_cnt, state_led, err, special_seen
  );
  modport slave (
    output key_valid, key_code, op_ready,
    input  op_valid, op_a, op_b, entry_word, digit_cnt, state_led, err, special_seen
  );
`else
  modport master (
    input  key_valid, key_code, op_ready,
    output op_valid, op_a, op_b, entry_word, digit_cnt, state_led, err
  );
  modport slave (
    output key_valid, key_code, op_ready,
    input  op_valid, op_a, op_b, entry_word, digit_cnt, state_led, err
  );
`endif

endinterface

// File: rtl/keypad_hex_decode.sv
// Maps a raw keypad index to a hex nibble or a control-key flag.
module keypad_hex_decode #(
  parameter int KEY_BKSP  = fp_entry_pkg::DEF_KEY_BKSP,
  parameter int KEY_ENTER = fp_entry_pkg::DEF_KEY_ENTER
) (
  input  logic [3:0] i_key_code,
  output logic [3:0] o_nibble,
  output logic       o_is_digit,
  output logic       o_is_bksp,
  output logic       o_is_enter
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    o_nibble   = 4'h0;
    o_is_digit = 1'b0;
    o_is_bksp  = 1'b0;
    o_is_enter = 1'b0;
    if (i_key_code == 4'(KEY_BKSP)) begin
      o_is_bksp = 1'b1;
    end else if (i_key_code == 4'(KEY_ENTER)) begin
      o_is_enter = 1'b1;
    end else begin
      o_is_digit = 1'b1;
      case (i_key_code)
        4'd0:    o_nibble = 4'h1;
        4'd1:    o_nibble = 4'h2;
        4'd2:    o_nibble = 4'h3;
        4'd3:    o_nibble = 4'hA;
        4'd4:    o_nibble = 4'h4;
        4'd5:    o_nibble = 4'h5;
        4'd6:    o_nibble = 4'h6;
        4'd7:    o_nibble = 4'hB;
        4'd8:    o_nibble = 4'h7;
        4'd9:    o_nibble = 4'h8;
        4'd10:   o_nibble = 4'h9;
        4'd11:   o_nibble = 4'hC;
        4'd13:   o_nibble = 4'h0;
        4'd15:   o_nibble = 4'hD;
        default: o_is_digit = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/fp16_operand_entry.sv
// Builds FP16 operands A then B from keypad digits and hands the pair off via valid/ready.
// Optional FP16_SPECIAL_REJECT_EN: refuse Inf/NaN words on enter and flag special_seen.
module fp16_operand_entry
  import fp_entry_pkg::*;
#(
  parameter int DIGITS    = DEF_DIGITS,
  parameter int KEY_BKSP  = DEF_KEY_BKSP,
  parameter int KEY_ENTER = DEF_KEY_ENTER
) (
  input logic                clk,
  input logic                reset,
  fp16_operand_entry_if.master bus
);

  localparam int         W        = 4 * DIGITS;
  localparam logic [2:0] CNT_FULL = 3'(DIGITS);

  logic [3:0] w_nibble;
  logic       w_is_digit, w_is_bksp, w_is_enter;
  logic       w_full, w_empty;

  state_e       r_state;
  logic [W-1:0] r_entry, r_op_a, r_op_b;
  logic [2:0]   r_cnt;
  logic         r_op_valid, r_err;
`ifdef FP16_SPECIAL_REJECT_EN
  logic         r_special_seen;
`endif

  keypad_hex_decode #(
    .KEY_BKSP  (KEY_BKSP),
    .KEY_ENTER (KEY_ENTER)
  ) u_decode (
    .i_key_code (bus.key_code),
    .o_nibble   (w_nibble),
    .o_is_digit (w_is_digit),
    .o_is_bksp  (w_is_bksp),
    .o_is_enter (w_is_enter)
  );

  assign w_full  = (r_cnt == CNT_FULL);
  assign w_empty = (r_cnt == 3'd0);

  // NOTE: all state updates use non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ENTER_A;
      r_entry    <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_cnt      <= 3'd0;
      r_op_valid <= 1'b0;
      r_err      <= 1'b0;
`ifdef FP16_SPECIAL_REJECT_EN
      r_special_seen <= 1'b0;
`endif
    end else begin
      r_err <= 1'b0;
      if (r_state == HOLD) begin
        // Keys are refused while the pair is on offer, even in the transfer cycle.
        if (bus.key_valid) r_err <= 1'b1;
        if (r_op_valid && bus.op_ready) begin
          r_op_valid <= 1'b0;
          r_state    <= ENTER_A;
        end
      end else if (bus.key_valid) begin
        if (w_is_digit) begin
          if (!w_full) begin
            r_entry <= {r_entry[W-5:0], w_nibble};
            r_cnt   <= r_cnt + 3'd1;
          end else begin
            r_err <= 1'b1;
          end
        end else if (w_is_bksp) begin
          if (!w_empty) begin
            r_entry <= r_entry >> 4;
            r_cnt   <= r_cnt - 3'd1;
          end else begin
            r_err <= 1'b1;
          end
        end else if (w_is_enter) begin
          if (!w_full) begin
            r_err <= 1'b1;
`ifdef FP16_SPECIAL_REJECT_EN
          end else if (fp16_is_special(r_entry)) begin
            r_err          <= 1'b1;
            r_special_seen <= 1'b1;
`endif
          end else begin
`ifdef FP16_SPECIAL_REJECT_EN
            r_special_seen <= 1'b0;
`endif
            r_entry <= '0;
            r_cnt   <= 3'd0;
            if (r_state == ENTER_A) begin
              r_op_a  <= r_entry;
              r_state <= ENTER_B;
            end else begin
              r_op_b     <= r_entry;
              r_state    <= HOLD;
              r_op_valid <= 1'b1;
            end
          end
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign bus.op_valid   = r_op_valid;
  assign bus.op_a       = r_op_a;
  assign bus.op_b       = r_op_b;
  assign bus.entry_word = r_entry;
  assign bus.digit_cnt  = r_cnt;
  assign bus.state_led  = r_state;
  assign bus.err        = r_err;
`ifdef FP16_SPECIAL_REJECT_EN
  assign bus.special_seen = r_special_seen;
`endif

endmodule

// File: tb/tb_fp16_operand_entry.sv
// Directed bench for fp16_operand_entry: queue-based reference model checked every cycle plus literal checks.
module tb_fp16_operand_entry;
  import fp_entry_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmp_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fp16_operand_entry_if bus ();
  fp16_operand_entry_if bus2 ();

  fp16_operand_entry dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  fp16_operand_entry #(.KEY_BKSP(15)) dut_remap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_state   = 0;   // 0 = A, 1 = B, 2 = hold
  bit [3:0]    m_dig[$];
  logic [15:0] m_a       = '0;
  logic [15:0] m_b       = '0;
  bit          m_valid   = 1'b0;
  bit          m_err     = 1'b0;
  bit          m_special = 1'b0;
  int          m_kv;
  logic [15:0] m_w;
  bit          m_rej;

  // -1 unmapped, -2 backspace, -3 enter, else hex value
  function automatic int key_meaning(input logic [3:0] code);
    int table_v[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, -2, 0, -3, 13};
    return table_v[code];
  endfunction

  function automatic logic [15:0] model_word();
    int w = 0;
    foreach (m_dig[i]) w = w * 16 + int'(m_dig[i]);
    return 16'(w);
  endfunction

  always @(posedge clk) begin
    m_err = 1'b0;
    if (reset) begin
      m_state = 0; m_dig.delete(); m_a = '0; m_b = '0; m_valid = 1'b0; m_special = 1'b0;
    end else if (m_state == 2) begin
      if (bus.key_valid) m_err = 1'b1;
      if (bus.op_ready) begin
        m_valid = 1'b0;
        m_state = 0;
      end
    end else if (bus.key_valid) begin
      m_kv = key_meaning(bus.key_code);
      if (m_kv >= 0) begin
        if (m_dig.size() < 4) m_dig.push_back(4'(m_kv));
        else m_err = 1'b1;
      end else if (m_kv == -2) begin
        if (m_dig.size() > 0) void'(m_dig.pop_back());
        else m_err = 1'b1;
      end else if (m_kv == -3) begin
        if (m_dig.size() != 4) begin
          m_err = 1'b1;
        end else begin
          m_w   = model_word();
          m_rej = 1'b0;
`ifdef FP16_SPECIAL_REJECT_EN
          m_rej = ((int'(m_w) / 1024) % 32) == 31;
`endif
          if (m_rej) begin
            m_err = 1'b1;
            m_special = 1'b1;
          end else begin
            m_special = 1'b0;
            m_dig.delete();
            if (m_state == 0) begin
              m_a = m_w;
              m_state = 1;
            end else begin
              m_b = m_w;
              m_state = 2;
              m_valid = 1'b1;
            end
          end
        end
      end else begin
        m_err = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model op_valid", 32'(bus.op_valid), 32'(m_valid));
      check("model op_a", 32'(bus.op_a), 32'(m_a));
      check("model op_b", 32'(bus.op_b), 32'(m_b));
      check("model entry_word", 32'(bus.entry_word), 32'(model_word()));
      check("model digit_cnt", 32'(bus.digit_cnt), 32'(m_dig.size()));
      check("model state_led", 32'(bus.state_led), 32'(m_state));
      check("model err", 32'(bus.err), 32'(m_err));
`ifdef FP16_SPECIAL_REJECT_EN
      check("model special_seen", 32'(bus.special_seen), 32'(m_special));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic kv, input logic [3:0] code);
    bus.key_valid = kv;
    bus.key_code  = code;
    @(posedge clk);
    #2;
    bus.key_valid = 1'b0;
  endtask

  task automatic key(input logic [3:0] code);
    step(1'b1, code);
  endtask

  task automatic key2(input logic [3:0] code);
    bus2.key_valid = 1'b1;
    bus2.key_code  = code;
    @(posedge clk);
    #2;
    bus2.key_valid = 1'b0;
  endtask

  initial begin
    bus.key_valid  = 1'b0; bus.key_code  = 4'd0; bus.op_ready  = 1'b0;
    bus2.key_valid = 1'b0; bus2.key_code = 4'd0; bus2.op_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset  = 1'b0;
    cmp_en = 1'b1;

    check("reset state_led", 32'(bus.state_led), 32'd0);
    check("reset op_valid", 32'(bus.op_valid), 32'd0);
    check("reset entry_word", 32'(bus.entry_word), 32'd0);
    check("reset op_a", 32'(bus.op_a), 32'd0);

    // Digits shift in MSD first
    key(4'd13); key(4'd0);
    check("entry 0x0001", 32'(bus.entry_word), 32'h0001);
    key(4'd13); key(4'd13);
    check("entry 0x0100", 32'(bus.entry_word), 32'h0100);
    check("cnt full", 32'(bus.digit_cnt), 32'd4);
    repeat (4) key(4'd12);
    key(4'd12);
    check("bksp on empty err", 32'(bus.err), 32'd1);

    key(4'd2); key(4'd11);
    check("entry 0x003C", 32'(bus.entry_word), 32'h003C);
    key(4'd12);
    check("bksp -> 0x0003", 32'(bus.entry_word), 32'h0003);
    check("bksp cnt 1", 32'(bus.digit_cnt), 32'd1);
    key(4'd12);
    key(4'd12);
    check("second bksp err", 32'(bus.err), 32'd1);
    check("second bksp cnt 0", 32'(bus.digit_cnt), 32'd0);

    // Operand A = 0x3C00, with a rejected fifth digit
    key(4'd2); key(4'd11); key(4'd13); key(4'd13);
    key(4'd4);
    check("fifth digit err", 32'(bus.err), 32'd1);
    check("fifth digit word kept", 32'(bus.entry_word), 32'h3C00);
    key(4'd14);
    check("A accepted state", 32'(bus.state_led), 32'd1);
    check("A latched", 32'(bus.op_a), 32'h3C00);

    // Operand B: short enter rejected, then 0x4000
    key(4'd4); key(4'd13); key(4'd13); key(4'd14);
    check("short enter err", 32'(bus.err), 32'd1);
    check("short enter cnt", 32'(bus.digit_cnt), 32'd3);
    check("short enter state", 32'(bus.state_led), 32'd1);
    key(4'd13); key(4'd14);
    check("hold op_valid", 32'(bus.op_valid), 32'd1);
    check("hold state_led", 32'(bus.state_led), 32'd2);
    check("hold op_b", 32'(bus.op_b), 32'h4000);

    // HOLD with op_ready low, one stray key
    step(1'b0, 4'd0);
    key(4'd0);
    check("hold key err", 32'(bus.err), 32'd1);
    repeat (3) step(1'b0, 4'd0);
    check("hold stays valid", 32'(bus.op_valid), 32'd1);
    check("hold op_a stable", 32'(bus.op_a), 32'h3C00);
    bus.op_ready = 1'b1;
    key(4'd5);
    check("transfer op_valid low", 32'(bus.op_valid), 32'd0);
    check("transfer state A", 32'(bus.state_led), 32'd0);
    check("transfer-cycle key err", 32'(bus.err), 32'd1);
    check("op_a kept", 32'(bus.op_a), 32'h3C00);
    step(1'b0, 4'd0);
    bus.op_ready = 1'b0;

    // Reset in the middle of operand B
    key(4'd0); key(4'd1); key(4'd2); key(4'd4); key(4'd14);
    check("A 0x1234", 32'(bus.op_a), 32'h1234);
    key(4'd15); key(4'd7);
    check("B partial 0x00DB", 32'(bus.entry_word), 32'h00DB);
    reset = 1'b1;
    step(1'b0, 4'd0);
    reset = 1'b0;
    check("mid-B reset op_a", 32'(bus.op_a), 32'd0);
    check("mid-B reset state", 32'(bus.state_led), 32'd0);
    check("mid-B reset cnt", 32'(bus.digit_cnt), 32'd0);

    // Remapped backspace: code 12 becomes unmapped, 15 is backspace
    key2(4'd0);
    check("remap digit", 32'(bus2.entry_word), 32'h0001);
    key2(4'd12);
    check("remap code12 err", 32'(bus2.err), 32'd1);
    check("remap code12 word", 32'(bus2.entry_word), 32'h0001);
    key2(4'd15);
    check("remap bksp", 32'(bus2.digit_cnt), 32'd0);

    // Inf pattern 0x7C00
    key(4'd8); key(4'd11); key(4'd13); key(4'd13); key(4'd14);
`ifdef FP16_SPECIAL_REJECT_EN
    check("inf rejected err", 32'(bus.err), 32'd1);
    check("inf special_seen", 32'(bus.special_seen), 32'd1);
    check("inf state kept", 32'(bus.state_led), 32'd0);
    check("inf digits kept", 32'(bus.digit_cnt), 32'd4);
    key(4'd12); key(4'd4); key(4'd14);
    check("0x7C04 rejected", 32'(bus.err), 32'd1);
    repeat (4) key(4'd12);
    key(4'd2); key(4'd11); key(4'd13); key(4'd13); key(4'd14);
    check("normal accepted", 32'(bus.state_led), 32'd1);
    check("special cleared", 32'(bus.special_seen), 32'd0);
`else
    check("inf accepted state", 32'(bus.state_led), 32'd1);
    check("inf accepted op_a", 32'(bus.op_a), 32'h7C00);
    check("inf accepted no err", 32'(bus.err), 32'd0);
`endif

    repeat (3) step(1'b0, 4'd0);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
